contador_lotes: RTL and testbench

CONTADOR_LOTES -- requirements
Module: contador_lotes

---
 rtl/contador_lotes_if.sv | 41 ++++
 rtl/contador_lotes.sv | 217 +++++++++++++++++++++
 tb/tb_contador_lotes.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/contador_lotes_if.sv
`default_nettype none
// ============================================================================
// Module      : contador_lotes_if
// Description : Bundle of the counting/stock signals of contador_lotes.
//               master = producer of the level inputs (line controller / TB)
//               slave  = contador_lotes itself
//   item, rolha_add, rolha_use, lot_ack, clear : level inputs to the counter
//   item_count, pack_bcd, lot_full, lot_done   : lot counting status
//   stock_bcd, stock_low, stock_empty, use_err : cork stock status
// Revision    : 1.0 - initial release
// ============================================================================
interface contador_lotes_if #(
    parameter int DIGITS = 2
);
    logic                  item;
    logic                  rolha_add;
    logic                  rolha_use;
    logic                  lot_ack;
    logic                  clear;
    logic [7:0]            item_count;
    logic [4*DIGITS-1:0]   pack_bcd;
    logic                  lot_full;
    logic                  lot_done;
    logic [4*DIGITS-1:0]   stock_bcd;
    logic                  stock_low;
    logic                  stock_empty;
    logic                  use_err;

    modport master (
        output item, rolha_add, rolha_use, lot_ack, clear,
        input  item_count, pack_bcd, lot_full, lot_done,
        input  stock_bcd, stock_low, stock_empty, use_err
    );

    modport slave (
        input  item, rolha_add, rolha_use, lot_ack, clear,
        output item_count, pack_bcd, lot_full, lot_done,
        output stock_bcd, stock_low, stock_empty, use_err
    );
endinterface
`default_nettype wire

// File: rtl/contador_lotes.sv
`default_nettype none
// ============================================================================
// Module      : contador_lotes
// Description : Bottle/pack/lot counter with a BCD cork-stock register.
//               Items accumulate into packs of PACK_SIZE; packs (BCD) into a
//               lot of PACKS_PER_LOT. A full lot is held until lot_ack (or is
//               released automatically when AUTO_REPOR = 1). A separate BCD
//               stock counts corks added/used, saturating at STOCK_MAX and
//               flagging a use request on an empty stock.
// Ports       : clock, reset (async, active-high)
//               bus (contador_lotes_if.slave): level inputs and status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module contador_lotes #(
    parameter int PACK_SIZE     = 12,
    parameter int PACKS_PER_LOT = 10,
    parameter int DIGITS        = 2,
    parameter int STOCK_MAX     = 99,
    parameter int STOCK_LOW     = 5,
    parameter int AUTO_REPOR    = 0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    contador_lotes_if.slave    bus
);

    localparam int W = 4 * DIGITS;

    // Binary-to-BCD conversion, used only on parameters at elaboration.
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    // BCD +1 with decimal carry; callers guarantee no overflow past the top.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic         carry;
        r     = x;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (x[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = x[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with decimal borrow; callers guarantee x != 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic         borrow;
        r      = x;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (x[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = x[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [7:0]   c_ITEM_LAST = 8'(PACK_SIZE - 1);
    localparam logic [W-1:0] c_LOT_BCD   = to_bcd(PACKS_PER_LOT);
    localparam logic [W-1:0] c_MAX_BCD   = to_bcd(STOCK_MAX);
    localparam logic [W-1:0] c_LOW_BCD   = to_bcd(STOCK_LOW);

    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       state_q,      state_d;
    logic [7:0]   item_count_q, item_count_d;
    logic [W-1:0] pack_q,       pack_d;
    logic [W-1:0] stock_q,      stock_d;
    logic         lot_done_q,   lot_done_d;
    logic         use_err_q,    use_err_d;

    // Input history; reset to 1 so a level already high at reset release is
    // not mistaken for a fresh event.
    logic item_h_q, add_h_q, use_h_q, ack_h_q;

    logic         w_item_ev, w_add_ev, w_use_ev, w_ack_ev;
    logic [W-1:0] w_pack_inc;

    assign w_item_ev = bus.item      & ~item_h_q;
    assign w_add_ev  = bus.rolha_add & ~add_h_q;
    assign w_use_ev  = bus.rolha_use & ~use_h_q;
    assign w_ack_ev  = bus.lot_ack   & ~ack_h_q;

    assign w_pack_inc = bcd_inc(pack_q);

    // ------------------------------------------------------------------
    // State / counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_COUNT;
            item_count_q <= 8'd0;
            pack_q       <= '0;
            stock_q      <= '0;
            lot_done_q   <= 1'b0;
            use_err_q    <= 1'b0;
            item_h_q     <= 1'b1;
            add_h_q      <= 1'b1;
            use_h_q      <= 1'b1;
            ack_h_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            item_count_q <= item_count_d;
            pack_q       <= pack_d;
            stock_q      <= stock_d;
            lot_done_q   <= lot_done_d;
            use_err_q    <= use_err_d;
            item_h_q     <= bus.item;
            add_h_q      <= bus.rolha_add;
            use_h_q      <= bus.rolha_use;
            ack_h_q      <= bus.lot_ack;
        end
    end

    // ------------------------------------------------------------------
    // Counting FSM: next state and counter updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        item_count_d = item_count_q;
        pack_d       = pack_q;
        lot_done_d   = 1'b0;

        if (bus.clear) begin
            // clear wins over any item/ack event on the same edge
            state_d      = ST_COUNT;
            item_count_d = 8'd0;
            pack_d       = '0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (w_item_ev) begin
                        if (item_count_q == c_ITEM_LAST) begin
                            item_count_d = 8'd0;
                            pack_d       = w_pack_inc;
                            if (w_pack_inc == c_LOT_BCD) begin
                                lot_done_d = 1'b1;
                                state_d    = ST_FULL;
                            end
                        end else begin
                            item_count_d = item_count_q + 8'd1;
                        end
                    end
                end
                ST_FULL: begin
                    // Items are dropped while full; release on ack or, in
                    // automatic mode, unconditionally after one cycle.
                    if ((AUTO_REPOR != 0) || w_ack_ev) begin
                        state_d      = ST_COUNT;
                        item_count_d = 8'd0;
                        pack_d       = '0;
                    end
                end
                default: begin
                    state_d = ST_COUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cork stock: simultaneous add+use cancel out (and suppress use_err)
    // ------------------------------------------------------------------
    always_comb begin
        stock_d   = stock_q;
        use_err_d = 1'b0;
        if (w_add_ev && !w_use_ev) begin
            if (stock_q != c_MAX_BCD) begin
                stock_d = bcd_inc(stock_q);
            end
        end else if (w_use_ev && !w_add_ev) begin
            if (stock_q == '0) begin
                use_err_d = 1'b1;
            end else begin
                stock_d = bcd_dec(stock_q);
            end
        end
    end

    // Packed BCD with valid digits orders the same as the decimal value,
    // so a plain unsigned compare gives the threshold test.
    assign bus.item_count  = item_count_q;
    assign bus.pack_bcd    = pack_q;
    assign bus.lot_full    = (state_q == ST_FULL);
    assign bus.lot_done    = lot_done_q;
    assign bus.stock_bcd   = stock_q;
    assign bus.stock_low   = (stock_q <= c_LOW_BCD);
    assign bus.stock_empty = (stock_q == '0);
    assign bus.use_err     = use_err_q;

endmodule
`default_nettype wire

// File: tb/tb_contador_lotes.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_lotes
// Description : Directed self-checking bench for contador_lotes. Instance A
//               uses defaults (manual lot release), instance B uses
//               AUTO_REPOR = 1. Inputs change on the falling edge; outputs
//               are checked on the falling edge after the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_lotes;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt_a;

    contador_lotes_if #(.DIGITS(2)) bus_a ();
    contador_lotes_if #(.DIGITS(2)) bus_b ();

    contador_lotes #(.AUTO_REPOR(0)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a.slave)
    );

    contador_lotes #(.AUTO_REPOR(1)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lot_done pulses of instance A, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst && bus_a.lot_done) done_cnt_a++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_item_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.item = 1'b1; tick();
            bus_a.item = 1'b0; tick();
        end
    endtask

    task automatic pulse_item_b(input int n);
        for (int i = 0; i < n; i++) begin
            bus_b.item = 1'b1; tick();
            bus_b.item = 1'b0; tick();
        end
    endtask

    task automatic pulse_add_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.rolha_add = 1'b1; tick();
            bus_a.rolha_add = 1'b0; tick();
        end
    endtask

    task automatic pulse_use_a(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.rolha_use = 1'b1; tick();
            bus_a.rolha_use = 1'b0; tick();
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done_cnt_a = 0;
        rst        = 1'b1;
        bus_a.item = 1'b0; bus_a.rolha_add = 1'b0; bus_a.rolha_use = 1'b0;
        bus_a.lot_ack = 1'b0; bus_a.clear = 1'b0;
        bus_b.item = 1'b0; bus_b.rolha_add = 1'b0; bus_b.rolha_use = 1'b0;
        bus_b.lot_ack = 1'b0; bus_b.clear = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_item_count", 32'(bus_a.item_count), 32'h0);
        check("rst_pack",       32'(bus_a.pack_bcd),   32'h00);
        check("rst_lot_full",   32'(bus_a.lot_full),   32'h0);
        check("rst_lot_done",   32'(bus_a.lot_done),   32'h0);
        check("rst_stock",      32'(bus_a.stock_bcd),  32'h00);
        check("rst_stock_low",  32'(bus_a.stock_low),  32'h1);
        check("rst_stock_empty",32'(bus_a.stock_empty),32'h1);
        check("rst_use_err",    32'(bus_a.use_err),    32'h0);
        rst = 1'b0;
        tick();

        // ---------------- one pack ----------------
        pulse_item_a(11);
        check("item_11", 32'(bus_a.item_count), 32'd11);
        pulse_item_a(1);
        check("item_wrap",  32'(bus_a.item_count), 32'd0);
        check("pack_01",    32'(bus_a.pack_bcd),   32'h01);

        // a level held high counts once
        bus_a.item = 1'b1; tick(); tick(); tick();
        bus_a.item = 1'b0; tick();
        check("item_level_once", 32'(bus_a.item_count), 32'd1);

        // ---------------- full lot, manual release ----------------
        pulse_item_a(106);                      // 13 + 106 = 119 items
        check("pack_09", 32'(bus_a.pack_bcd),   32'h09);
        check("item_119",32'(bus_a.item_count), 32'd11);
        bus_a.item = 1'b1; tick();              // item 120
        check("lot_done_a", 32'(bus_a.lot_done), 32'h1);
        check("lot_full_a", 32'(bus_a.lot_full), 32'h1);
        check("pack_10",    32'(bus_a.pack_bcd), 32'h10);
        bus_a.item = 1'b0; tick();
        check("lot_done_a_end", 32'(bus_a.lot_done), 32'h0);
        check("lot_full_hold",  32'(bus_a.lot_full), 32'h1);
        pulse_item_a(5);                        // items 121-125 dropped
        check("full_item_ignored", 32'(bus_a.item_count), 32'd0);
        check("full_pack_held",    32'(bus_a.pack_bcd),   32'h10);
        check("full_still",        32'(bus_a.lot_full),   32'h1);
        check("lot_done_once",     32'(done_cnt_a),       32'd1);
        bus_a.lot_ack = 1'b1; tick();
        check("ack_pack", 32'(bus_a.pack_bcd), 32'h00);
        check("ack_full", 32'(bus_a.lot_full), 32'h0);
        bus_a.lot_ack = 1'b0; tick();

        // ack in COUNT is inert; clear wins over an item event
        pulse_item_a(3);
        bus_a.lot_ack = 1'b1; tick(); bus_a.lot_ack = 1'b0; tick();
        check("ack_in_count", 32'(bus_a.item_count), 32'd3);
        bus_a.clear = 1'b1; bus_a.item = 1'b1; tick();
        bus_a.clear = 1'b0; bus_a.item = 1'b0; tick();
        check("clear_item", 32'(bus_a.item_count), 32'd0);

        // ---------------- full lot, automatic release ----------------
        pulse_item_b(119);
        check("b_pack_09", 32'(bus_b.pack_bcd), 32'h09);
        bus_b.item = 1'b1; tick();
        check("b_lot_done", 32'(bus_b.lot_done), 32'h1);
        check("b_lot_full", 32'(bus_b.lot_full), 32'h1);
        check("b_pack_10",  32'(bus_b.pack_bcd), 32'h10);
        bus_b.item = 1'b0; tick();
        check("b_lot_done_end", 32'(bus_b.lot_done), 32'h0);
        check("b_lot_full_end", 32'(bus_b.lot_full), 32'h0);
        check("b_pack_00",      32'(bus_b.pack_bcd), 32'h00);
        pulse_item_b(1);
        check("b_item_121", 32'(bus_b.item_count), 32'd1);

        // ---------------- cork stock ----------------
        pulse_add_a(10);
        check("stock_10", 32'(bus_a.stock_bcd), 32'h10);
        pulse_use_a(1);
        check("stock_09", 32'(bus_a.stock_bcd), 32'h09);
        pulse_use_a(3);
        check("stock_06",     32'(bus_a.stock_bcd), 32'h06);
        check("stock_low_06", 32'(bus_a.stock_low), 32'h0);
        pulse_use_a(1);
        check("stock_low_05", 32'(bus_a.stock_low), 32'h1);
        check("clear_keeps_stock_pre", 32'(bus_a.stock_bcd), 32'h05);
        bus_a.clear = 1'b1; tick(); bus_a.clear = 1'b0; tick();
        check("clear_keeps_stock", 32'(bus_a.stock_bcd), 32'h05);
        pulse_add_a(94);
        check("stock_99", 32'(bus_a.stock_bcd), 32'h99);
        pulse_add_a(1);
        check("stock_sat", 32'(bus_a.stock_bcd), 32'h99);
        pulse_use_a(99);
        check("stock_00",    32'(bus_a.stock_bcd),   32'h00);
        check("stock_empty", 32'(bus_a.stock_empty), 32'h1);
        bus_a.rolha_use = 1'b1; tick();
        check("use_err_pulse", 32'(bus_a.use_err),   32'h1);
        check("use_err_stock", 32'(bus_a.stock_bcd), 32'h00);
        bus_a.rolha_use = 1'b0; tick();
        check("use_err_end", 32'(bus_a.use_err), 32'h0);
        bus_a.rolha_add = 1'b1; bus_a.rolha_use = 1'b1; tick();
        check("add_use_stock", 32'(bus_a.stock_bcd), 32'h00);
        check("add_use_noerr", 32'(bus_a.use_err),   32'h0);
        bus_a.rolha_add = 1'b0; bus_a.rolha_use = 1'b0; tick();

        // ---------------- asynchronous reset mid-lot ----------------
        pulse_item_a(55);                       // 4 packs + 7 items
        check("mid_item_7", 32'(bus_a.item_count), 32'd7);
        check("mid_pack_04",32'(bus_a.pack_bcd),   32'h04);
        #2 rst = 1'b1;
        #1;
        check("async_item", 32'(bus_a.item_count), 32'd0);
        check("async_pack", 32'(bus_a.pack_bcd),   32'h00);
        bus_a.item = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        check("held_no_count", 32'(bus_a.item_count), 32'd0);
        bus_a.item = 1'b0; tick();
        bus_a.item = 1'b1; tick();
        check("reedge_count", 32'(bus_a.item_count), 32'd1);
        bus_a.item = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
